// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the 32x32 register file
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/regfile_cell.sv
// regfile_cell: one register with async active-low clear and synchronous load (clk, Reset, load, d -> q)
module regfile_cell
    import regfile_pkg::*;
(
    input  logic  clk,
    input  logic  Reset,
    input  logic  load,
    input  data_t d,
    output data_t q
);
    always_ff @(posedge clk or negedge Reset)
        if (!Reset) q <= '0;
        else if (load) q <= d;
endmodule

// File: rtl/register_file_32bits.sv
// register_file_32bits: 32x32 register file, two combinational read ports, one write port, r0 reads zero
// Ports: clk, Reset (async active-low), DIn/WrtAdd/Wenable write, RdAdd1->DataA, RdAdd2->DataB.
// Optional REGFILE_WRITE_BYPASS_EN forwards DIn to a read port addressing the register being written.
module register_file_32bits
    import regfile_pkg::*;
(
    input  logic  clk,
    input  logic  Reset,
    input  data_t DIn,
    output data_t DataA,
    output data_t DataB,
    input  addr_t RdAdd1,
    input  addr_t RdAdd2,
    input  addr_t WrtAdd,
    input  logic  Wenable
);
    data_t regs [NUM_REGS];
    assign regs[0] = '0;
    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_cell
            regfile_cell u_cell (
                .clk  (clk),
                .Reset(Reset),
                .load (Wenable && WrtAdd == addr_t'(g)),
                .d    (DIn),
                .q    (regs[g])
            );
        end
    endgenerate
`ifdef REGFILE_WRITE_BYPASS_EN
    logic fwd;
    assign fwd   = Reset && Wenable && WrtAdd != ZERO_REG;
    assign DataA = (fwd && RdAdd1 == WrtAdd) ? DIn : regs[RdAdd1];
    assign DataB = (fwd && RdAdd2 == WrtAdd) ? DIn : regs[RdAdd2];
`else
    assign DataA = regs[RdAdd1];
    assign DataB = regs[RdAdd2];
`endif
endmodule

// File: tb/tb_register_file_32bits.sv
// tb_register_file_32bits: directed table-driven check of register_file_32bits
module tb_register_file_32bits;
    import regfile_pkg::*;
`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic  clk = 1'b0;
    logic  Reset = 1'b0;
    data_t DIn = '0;
    data_t DataA, DataB;
    addr_t RdAdd1 = '0, RdAdd2 = '0, WrtAdd = '0;
    logic  Wenable = 1'b0;
    int    n_chk = 0;
    int    n_fail = 0;
    typedef struct {
        logic  wen;
        addr_t wadd;
        data_t din;
        addr_t ra1;
        addr_t ra2;
        data_t exp_a;
        data_t exp_b;
    } vec_t;
    vec_t vecs [6];
    register_file_32bits dut (
        .clk    (clk),
        .Reset  (Reset),
        .DIn    (DIn),
        .DataA  (DataA),
        .DataB  (DataB),
        .RdAdd1 (RdAdd1),
        .RdAdd2 (RdAdd2),
        .WrtAdd (WrtAdd),
        .Wenable(Wenable)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input data_t act, input data_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        vecs[0] = '{1'b1, 5'd1,  32'h78493052, 5'd1,  5'd0, 32'h78493052, 32'h00000000};
        vecs[1] = '{1'b1, 5'd2,  32'h73245243, 5'd1,  5'd2, 32'h78493052, 32'h73245243};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd2, 32'h00000000, 32'h73245243};
        vecs[3] = '{1'b0, 5'd1,  32'h12345678, 5'd1,  5'd1, 32'h78493052, 32'h78493052};
        vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd2, 32'hCAFEF00D, 32'h73245243};
        vecs[5] = '{1'b1, 5'd3,  32'h11111111, 5'd3,  5'd3, 32'h11111111, 32'h11111111};
        RdAdd1 = 5'd7;
        RdAdd2 = 5'd31;
        #1;
        check("reset_a", DataA, '0);
        check("reset_b", DataB, '0);
        @(negedge clk);
        Reset = 1'b1;
        Wenable = 1'b1; WrtAdd = 5'd5; DIn = 32'hDEADBEEF; RdAdd1 = 5'd5;
        @(posedge clk); #1;
        check("load_r5", DataA, 32'hDEADBEEF);
        @(negedge clk);
        Wenable = 1'b0;
        #2 Reset = 1'b0;
        #1 check("async_clear_r5", DataA, '0);
        Reset = 1'b1;
        #1 check("r5_stays_clear", DataA, '0);
        @(negedge clk);
        Reset = 1'b0;
        Wenable = 1'b1; WrtAdd = 5'd6; DIn = 32'h55AA55AA; RdAdd2 = 5'd6;
        #1 check("no_bypass_in_reset", DataB, '0);
        @(posedge clk); #1;
        check("reset_blocks_write", DataB, '0);
        @(negedge clk);
        Reset = 1'b1;
        Wenable = 1'b0;
        #1 check("released_r6_zero", DataB, '0);
        foreach (vecs[i]) begin
            @(negedge clk);
            Wenable = vecs[i].wen; WrtAdd = vecs[i].wadd; DIn = vecs[i].din;
            RdAdd1 = vecs[i].ra1; RdAdd2 = vecs[i].ra2;
            @(posedge clk); #1;
            check($sformatf("vec%0d_a", i), DataA, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), DataB, vecs[i].exp_b);
        end
        @(negedge clk);
        Wenable = 1'b1; WrtAdd = 5'd3; RdAdd1 = 5'd3; RdAdd2 = 5'd3; DIn = 32'hA5A5A5A5;
        #1 check("same_addr_pre_edge", DataA, BYP ? 32'hA5A5A5A5 : 32'h11111111);
        @(posedge clk); #1;
        check("same_addr_post_edge", DataA, 32'hA5A5A5A5);
        @(negedge clk);
        Wenable = 1'b0;
        #1 check("same_addr_stored", DataB, 32'hA5A5A5A5);
        for (int i = 1; i < NUM_REGS; i++) begin
            @(negedge clk);
            Wenable = 1'b1; WrtAdd = addr_t'(i); DIn = data_t'(i) * 32'h01010101;
        end
        @(negedge clk);
        Wenable = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            RdAdd1 = addr_t'(i);
            RdAdd2 = addr_t'(NUM_REGS - 1 - i);
            #1;
            check($sformatf("sweep_a%0d", i), DataA, data_t'(i) * 32'h01010101);
            check($sformatf("sweep_b%0d", NUM_REGS - 1 - i), DataB, data_t'(NUM_REGS - 1 - i) * 32'h01010101);
        end
        RdAdd1 = 5'd17; RdAdd2 = 5'd31;
        Reset = 1'b0;
        #1;
        check("final_clear_a", DataA, '0);
        check("final_clear_b", DataB, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
